// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache controller: funct3 encodings,
// controller state type and line geometry constants.
package dcache_pkg;

  // Load encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Byte offset within a line and line size in words
  localparam int unsigned OFFSET_W       = 4;
  localparam int unsigned WORDS_PER_LINE = 4;

  typedef enum logic {
    IDLE,
    REFILL
  } dstate_t;

endpackage

// File: rtl/dcache_load_align.sv
// Load formatter: selects the byte/halfword lane of a cached word and
// sign- or zero-extends it according to funct3.
module dcache_load_align
  import dcache_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection followed by extension
  always_comb begin
    byte_sel = word[7:0];
    case (byte_off)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = byte_off[1] ? word[31:16] : word[15:0];

    data = '0;
    case (funct3)
      LB:      data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data = {24'd0, byte_sel};
      LH:      data = {{16{half_sel[15]}}, half_sel};
      LHU:     data = {16'd0, half_sel};
      LW:      data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Load hits answer combinationally; load misses stall while a 4-word line
// is refilled; stores always go straight to memory and patch the cache on
// a hit. Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module l1_dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 64,
  parameter int unsigned WPL   = WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - OFFSET_W - IDX_W;

  dstate_t state_q, state_d;
  logic [1:0]       cnt_q;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][WPL];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_word;
  logic             hit;
  logic [31:0]      hit_word;
  logic [31:0]      align_data;
  logic [31:0]      st_word;
  logic             st_ok;
  logic             refill_start;
  logic             refill_last;
  logic             store_hit;
  logic             load_hit;

  assign req_idx  = req_addr[OFFSET_W +: IDX_W];
  assign req_tag  = req_addr[31 -: TAG_W];
  assign req_word = req_addr[3:2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word = data_q[req_idx][req_word];
  assign st_ok    = (req_funct3 == SB) || (req_funct3 == SH) || (req_funct3 == SW);

  dcache_load_align u_align (
    .word     (hit_word),
    .funct3   (req_funct3),
    .byte_off (req_addr[1:0]),
    .data     (align_data)
  );

  // Merge store data into the cached word for a store hit
  always_comb begin
    st_word = hit_word;
    case (req_funct3)
      SB: begin
        case (req_addr[1:0])
          2'd0: st_word[7:0]   = req_wdata[7:0];
          2'd1: st_word[15:8]  = req_wdata[7:0];
          2'd2: st_word[23:16] = req_wdata[7:0];
          2'd3: st_word[31:24] = req_wdata[7:0];
          default: st_word = hit_word;
        endcase
      end
      SH: begin
        if (req_addr[1]) st_word[31:16] = req_wdata[15:0];
        else             st_word[15:0]  = req_wdata[15:0];
      end
      SW:      st_word = req_wdata;
      default: st_word = hit_word;
    endcase
  end

  // Controller state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and all outputs; everything reads zero while reset is held
  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    rdata        = '0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_funct3   = '0;
    refill_start = 1'b0;
    refill_last  = 1'b0;
    store_hit    = 1'b0;
    load_hit     = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_addr   = req_addr;
            mem_funct3 = req_funct3;
            if (req_we) begin
              mem_wdata = req_wdata;
              mem_we    = st_ok;
              store_hit = st_ok && hit;
            end else if (hit) begin
              rdata    = align_data;
              load_hit = 1'b1;
            end else begin
              stall        = 1'b1;
              refill_start = 1'b1;
              state_d      = REFILL;
            end
          end
        end
        REFILL: begin
          stall       = 1'b1;
          mem_funct3  = LW;
          mem_addr    = {req_tag, req_idx, cnt_q, 2'b00};
          refill_last = (cnt_q == 2'd3);
          if (refill_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Refill word counter and valid bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      if (refill_start)
        cnt_q <= '0;
      else if (state_q == REFILL)
        cnt_q <= cnt_q + 2'd1;
      if (refill_last)
        valid_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays (not reset); refill capture and store-hit patching
  // are mutually exclusive because store hits only occur in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == REFILL)
        data_q[req_idx][cnt_q] <= mem_rdata;
      if (refill_last)
        tag_q[req_idx] <= req_tag;
      if (store_hit)
        data_q[req_idx][req_word] <= st_word;
    end
  end

`ifdef DCACHE_STATS_EN
  // Hit/miss statistics, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit)     hit_count  <= hit_count + 32'd1;
      if (refill_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Self-checking bench for l1_dcache_ctrl: behavioural word memory plus a
// queue of expected load results popped when the cache releases stall.
module tb_l1_dcache_ctrl;

  localparam int unsigned LINES = 64;
  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [2:0] F_BAD = 3'b011;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        stall;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  logic [31:0] mem [4096];
  logic [31:0] exp_q [$];
  int checks;
  int failures;

  l1_dcache_ctrl #(.LINES(LINES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .stall      (stall),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[13:2]];

  // Word-addressed memory with byte-lane writes
  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_funct3)
        3'b000: mem[mem_addr[13:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
        3'b001: mem[mem_addr[13:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[13:2]] <= mem_wdata;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Load: push expectation, count stall cycles, check refill addresses, pop on release
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] exp, input int exp_stall, input string name);
    int n;
    logic [31:0] e;
    logic [35:0] ref_exp;
    exp_q.push_back(exp);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_funct3 = f3; req_wdata = '0;
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 20) begin
      if (n >= 1) begin
        ref_exp = {addr[31:4], 2'(n - 1), 2'b00, 1'b0, F_LW};
        checks++;
        if ({mem_addr, mem_we, mem_funct3} !== ref_exp)
          $display("FAIL %s refill%0d: got addr=%h we=%b f3=%b, want addr=%h we=0 f3=010",
                   name, n - 1, mem_addr, mem_we, mem_funct3, ref_exp[35:4]);
        if ({mem_addr, mem_we, mem_funct3} !== ref_exp) failures++;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != exp_stall) begin
      failures++;
      $display("FAIL %s stall_cycles: got %0d, want %0d", name, n, exp_stall);
    end
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      failures++;
      $display("FAIL %s rdata: got %h, want %h", name, rdata, e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Store: single-cycle write-through, then write enable must drop
  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] data, input logic exp_we, input string name);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_funct3 = f3; req_wdata = data;
    @(negedge clk);
    checks++;
    if ({stall, mem_we} !== {1'b0, exp_we}) begin
      failures++;
      $display("FAIL %s stall/we: got %b%b, want 0%b", name, stall, mem_we, exp_we);
    end
    if (exp_we) begin
      checks++;
      if ({mem_addr, mem_wdata, mem_funct3} !== {addr, data, f3}) begin
        failures++;
        $display("FAIL %s mem_bus: got %h %h %b, want %h %h %b",
                 name, mem_addr, mem_wdata, mem_funct3, addr, data, f3);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0) begin
      failures++;
      $display("FAIL %s we_drop: got %b, want 0", name, mem_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0104;
    req_wdata = 32'hA5A5_A5A5; req_funct3 = F_LW;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall, rdata, mem_we, mem_addr, mem_wdata, mem_funct3} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got stall=%b rdata=%h we=%b addr=%h wdata=%h f3=%b, want all 0",
               stall, rdata, mem_we, mem_addr, mem_wdata, mem_funct3);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, mem_we} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: got stall=%b we=%b, want 0 0", stall, mem_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_miss();
    do_load(32'h0000_0100, F_LW, 32'hDEAD_BEEF, 5, "lw_miss");
  endtask

  task automatic test_load_formats();
    do_load(32'h0000_0103, F_LB,  32'hFFFF_FFDE, 0, "lb_103");
    do_load(32'h0000_0103, F_LBU, 32'h0000_00DE, 0, "lbu_103");
    do_load(32'h0000_0102, F_LHU, 32'h0000_DEAD, 0, "lhu_102");
    do_load(32'h0000_0102, F_LH,  32'hFFFF_DEAD, 0, "lh_102");
    do_load(32'h0000_0100, F_LB,  32'hFFFF_FFEF, 0, "lb_100");
    do_load(32'h0000_0100, F_LHU, 32'h0000_BEEF, 0, "lhu_100");
    do_load(32'h0000_0104, F_LW,  32'h1111_2222, 0, "lw_104");
    do_load(32'h0000_010C, F_LW,  32'h7788_99AA, 0, "lw_10c");
    do_load(32'h0000_0100, F_BAD, 32'h0000_0000, 0, "bad_f3");
  endtask

  task automatic test_store_hit();
    do_store(32'h0000_0101, 3'b000, 32'h0000_0055, 1'b1, "sb_hit");
    do_load(32'h0000_0100, F_LW, 32'hDEAD_55EF, 0, "lw_after_sb");
    do_store(32'h0000_010E, 3'b001, 32'h0000_BEAD, 1'b1, "sh_hit");
    do_load(32'h0000_010C, F_LW, 32'hBEAD_99AA, 0, "lw_after_sh");
    do_store(32'h0000_0100, F_BAD, 32'hFFFF_FFFF, 1'b0, "bad_store");
    do_load(32'h0000_0100, F_LW, 32'hDEAD_55EF, 0, "lw_after_bad");
  endtask

  task automatic test_store_miss();
    do_store(32'h0000_2000, 3'b010, 32'h1234_5678, 1'b1, "sw_miss");
    do_load(32'h0000_2000, F_LW, 32'h1234_5678, 5, "lw_2000");
  endtask

  task automatic test_conflict();
    do_load(32'h0000_0100, F_LW, 32'hDEAD_55EF, 0, "conf_hit");
    do_load(32'h0000_0100 + LINES * 16, F_LW, 32'hCAFE_F00D, 5, "conf_other");
    do_load(32'h0000_0100, F_LW, 32'hDEAD_55EF, 5, "conf_back");
  endtask

  task automatic test_back_to_back();
    do_load(32'h0000_0108, F_LW,  32'h5555_6666, 0, "b2b_0");
    do_load(32'h0000_0109, F_LBU, 32'h0000_0066, 0, "b2b_1");
    do_load(32'h0000_2000, F_LH,  32'h0000_5678, 0, "b2b_2");
  endtask

  task automatic test_reset_mid_refill();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0100 + LINES * 16; req_funct3 = F_LW;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL midrst_miss_stall: got %b, want 1", stall);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, mem_addr} !== 33'd0) begin
      failures++;
      $display("FAIL midrst_outputs: got stall=%b addr=%h, want 0 0", stall, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL midrst_idle: got stall=%b, want 0", stall);
    end
    @(posedge clk); #1;
    do_load(32'h0000_0100, F_LW, 32'hDEAD_55EF, 5, "lw_after_midrst");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0BAD_0000 + i;
    mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    mem[32'h104 >> 2] = 32'h1111_2222;
    mem[32'h108 >> 2] = 32'h5555_6666;
    mem[32'h10C >> 2] = 32'h7788_99AA;
    mem[(32'h100 + LINES * 16) >> 2] = 32'hCAFE_F00D;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    @(posedge clk); #1;

    test_reset();
    test_load_miss();
    test_load_formats();
    test_store_hit();
    test_store_miss();
    test_back_to_back();
    test_conflict();
    test_reset_mid_refill();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l1_dcache_ctrl.md
# l1_dcache_ctrl

Direct-mapped, write-through, no-write-allocate L1 data cache sitting between the MEM pipeline stage and the word-addressed data memory. Load hits return formatted data in the same cycle. Load misses stall the pipeline while a 4-word line is refilled from memory. Stores are always written through to memory in a single cycle and update the cache only on a hit.

## Interface
Parameters:
- `LINES`, default 64: number of cache lines; must be a power of 2, at least 2.
- `WPL`, default 4: words per line; fixed at 4.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-low.
- `req_valid`, input, 1: MEM-stage access valid.
- `req_we`, input, 1: 1 = store, 0 = load.
- `req_addr`, input, 32: byte address.
- `req_wdata`, input, 32: store data.
- `req_funct3`, input, 3: load/store size (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
- `stall`, output, 1: pipeline must hold the request.
- `rdata`, output, 32: formatted load data; valid when `req_valid & !req_we & !stall`.
- `mem_addr`, output, 32: memory byte address.
- `mem_wdata`, output, 32: memory write data.
- `mem_we`, output, 1: memory write enable.
- `mem_funct3`, output, 3: memory access size.
- `mem_rdata`, input, 32: memory read data, combinational from `mem_addr`.

## Operation
Address split:
- offset = `addr[3:0]`: word = `[3:2]`, byte = `[1:0]`.
- index = `addr[4 +: log2(LINES)]`.
- tag = remaining upper bits.

Storage: per line one valid bit, one tag, and 4×32-bit data words.

State machine: `IDLE`, `REFILL`.

IDLE:
- Hit = `valid[index] & tag match`.
- Load hit:
  - `stall` = 0.
  - `rdata` is the formatted word:
    - LB/LBU: byte lane `addr[1:0]`, sign- or zero-extended.
    - LH/LHU: halfword lane `addr[1]`, sign- or zero-extended.
    - LW: full word.
    - Other funct3: 0.
- Load miss:
  - `stall` = 1.
  - Refill counter cleared to 0.
  - Next state `REFILL`.
- Store (hit or miss):
  - `stall` = 0.
  - `mem_we` = 1 for funct3 000/001/010; `mem_addr`/`mem_wdata`/`mem_funct3` pass through from the request.
  - On a hit, the same edge updates the cached byte lanes:
    - SB: lane `addr[1:0]`.
    - SH: lane `addr[1]`.
    - SW: full word.
  - Other funct3: no memory write, no cache update.
- `req_valid` = 0: `stall` = 0, `mem_we` = 0.

REFILL:
- `stall` = 1, `mem_we` = 0, `mem_funct3` = 010.
- `mem_addr` = `{req tag, req index, cnt, 2'b00}`.
- Each edge captures `mem_rdata` into word `cnt` and increments `cnt`.
- On `cnt` = 3: write the tag, set valid, next state `IDLE`.
- The request is re-evaluated in IDLE and now hits.

Arithmetic and boundary rules:
- Misaligned accesses are unsupported; only lane bits are used.
- `cnt` is 2 bits and wraps at 3 → `IDLE`.
- Conflict miss: the refill overwrites the line regardless of its prior valid state.
- The request is held stable by the pipeline while `stall` = 1; a change during `REFILL` is not supported.

## Timing
Latencies:
- Load hit: 0 extra cycles (combinational `rdata`).
- Load miss:
  - Miss cycle in IDLE, plus 4 `REFILL` cycles.
  - `stall` is high for 5 cycles.
  - Data is valid on the 6th cycle.
- Store: 1 cycle; memory and cache are written on the same edge.

Reset (`rst` = 0 at an edge), including mid-refill:
- State returns to `IDLE`.
- All valid bits cleared, `cnt` = 0.
- Counters cleared (when enabled).

Output values while `rst` is low:
- `stall` = 0, `rdata` = 0, `mem_we` = 0.
- `mem_addr` = 0, `mem_wdata` = 0, `mem_funct3` = 0.

Data array contents are not reset.

## Configuration
- `DCACHE_STATS_EN` defined: two 32-bit outputs are added.
  - `hit_count` increments on each load hit completing in IDLE.
  - `miss_count` increments on each IDLE→`REFILL` transition.
  - Both counters wrap at 2^32 and are cleared by reset.
  - A load that re-hits after a refill counts as one miss plus one hit.
- `DCACHE_STATS_EN` not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
Package `dcache_pkg`:
- funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
- State enum.
- Offset width constant (4).
- Words-per-line constant.

Sub-module `dcache_load_align`:
- Combinational word + funct3 + `addr[1:0]` → formatted 32-bit load data.
- Instanced once on the hit path.

## Test plan
- Reset, then LW 0x100 (memory word = 0xDEADBEEF) → `stall` high 5 cycles, `mem_addr` 0x100, 0x104, 0x108, 0x10C; then `rdata` = 0xDEADBEEF with `stall` = 0.
- After the refill above, LB 0x103 → `rdata` = 0xFFFFFFDE with no stall; LBU 0x103 → 0x000000DE; LHU 0x102 → 0x0000DEAD.
- SB 0x101 data 0x55 on a hit → `mem_we` = 1 for 1 cycle; next LW 0x100 → 0xDEAD55EF with no stall.
- SW 0x2000 (miss) data 0x12345678 → `mem_we` = 1, `stall` = 0; next LW 0x2000 misses and refills, returning 0x12345678.
- Conflict: LW 0x100, then LW 0x100 + (LINES×16) → second access refills (5-cycle stall); LW 0x100 again misses.
- Assert `rst` = 0 at the 2nd `REFILL` cycle → `stall` = 0, state `IDLE`; a subsequent LW 0x100 takes a full 5-cycle miss.
